// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch-controller handshake bundle
// Master side is the PC controller; slave side is the pipeline/memory.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall_pc;
  logic              fetch_ack;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_addr;
  logic              exc_flag;
  logic              eret_flag;
  logic              rom_en;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] epc;
  logic              addr_err;
  logic              pend_valid;

  modport master (
    input  stall_pc, fetch_ack, branch_flag, branch_addr, exc_flag, eret_flag,
    output rom_en, addr, epc, addr_err, pend_valid
  );

  modport slave (
    output stall_pc, fetch_ack, branch_flag, branch_addr, exc_flag, eret_flag,
    input  rom_en, addr, epc, addr_err, pend_valid
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program-counter fetch controller
// Sequences fetch addresses with exception, eret and branch redirects plus one pending slot.
module pc_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_0020),
  parameter int                ALIGN_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  pc_fetch_ctrl_if.master     bus
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(1) << ALIGN_BITS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP - ADDR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nx;

  logic              rom_en_q, rom_en_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ADDR_W-1:0] epc_q, epc_nx;
  logic              addr_err_q, addr_err_nx;
  logic              pend_valid_q, pend_valid_nx;
  logic              pend_prio_q, pend_prio_nx;
  logic [ADDR_W-1:0] pend_target_q, pend_target_nx;

  logic              advance;
  logic              take_exc;
  logic              misaligned;
  logic              redir_hit;
  logic              redir_prio;
  logic [ADDR_W-1:0] redir_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    rom_en_nx      = rom_en_q;
    addr_nx        = addr_q;
    epc_nx         = epc_q;
    addr_err_nx    = 1'b0;
    pend_valid_nx  = pend_valid_q;
    pend_prio_nx   = pend_prio_q;
    pend_target_nx = pend_target_q;
    take_exc       = 1'b0;
    redir_hit      = 1'b0;
    redir_prio     = 1'b0;
    redir_target   = '0;
    misaligned     = |(bus.branch_addr & ALIGN_MASK);
    advance        = (state == RUN) && bus.fetch_ack && !bus.stall_pc;

    case (state)
      IDLE: begin
        state_nx  = RUN;
        rom_en_nx = 1'b1;
      end
      RUN: begin
        state_nx  = RUN;
        rom_en_nx = 1'b1;

        // Classify this cycle's request in priority order.
        if (bus.exc_flag) begin
          take_exc = 1'b1;
        end else if (bus.eret_flag) begin
          redir_hit    = 1'b1;
          redir_prio   = 1'b1;
          redir_target = epc_q;
        end else if (bus.branch_flag) begin
          if (misaligned) begin
            take_exc    = 1'b1;
            addr_err_nx = 1'b1;
          end else begin
            redir_hit    = 1'b1;
            redir_prio   = 1'b0;
            redir_target = bus.branch_addr;
          end
        end

        if (take_exc) begin
          // Exceptions redirect even when the pipe is stalled.
          addr_nx       = EXC_VEC;
          epc_nx        = addr_q;
          pend_valid_nx = 1'b0;
          pend_prio_nx  = 1'b0;
        end else if (redir_hit) begin
          if (advance) begin
            addr_nx       = redir_target;
            pend_valid_nx = 1'b0;
            pend_prio_nx  = 1'b0;
          end else if (!pend_valid_q || (redir_prio >= pend_prio_q)) begin
            pend_valid_nx  = 1'b1;
            pend_prio_nx   = redir_prio;
            pend_target_nx = redir_target;
          end
        end else if (advance) begin
          if (pend_valid_q) begin
            addr_nx       = pend_target_q;
            pend_valid_nx = 1'b0;
            pend_prio_nx  = 1'b0;
          end else begin
            addr_nx = addr_q + STEP;
          end
        end
      end
      default: begin
        state_nx  = IDLE;
        rom_en_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en_q      <= 1'b0;
      addr_q        <= RESET_VEC;
      epc_q         <= '0;
      addr_err_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_prio_q   <= 1'b0;
      pend_target_q <= '0;
    end else begin
      rom_en_q      <= rom_en_nx;
      addr_q        <= addr_nx;
      epc_q         <= epc_nx;
      addr_err_q    <= addr_err_nx;
      pend_valid_q  <= pend_valid_nx;
      pend_prio_q   <= pend_prio_nx;
      pend_target_q <= pend_target_nx;
    end
  end

  assign bus.rom_en     = rom_en_q;
  assign bus.addr       = addr_q;
  assign bus.epc        = epc_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst8;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();
  pc_fetch_ctrl_if #(.ADDR_W(8))  bus8 ();

  pc_fetch_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  pc_fetch_ctrl #(.ADDR_W(8), .RESET_VEC(8'h00), .EXC_VEC(8'h20), .ALIGN_BITS(2)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    rst8 = 1'b1;
    bus.stall_pc = 0; bus.fetch_ack = 1; bus.branch_flag = 0; bus.branch_addr = '0;
    bus.exc_flag = 0; bus.eret_flag = 0;
    bus8.stall_pc = 0; bus8.fetch_ack = 0; bus8.branch_flag = 0; bus8.branch_addr = '0;
    bus8.exc_flag = 0; bus8.eret_flag = 0;
    step(); step();
    check("rst_rom_en", bus.rom_en, 0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_pend", bus.pend_valid, 0);
    check("rst_err", bus.addr_err, 0);

    // Reset release and sequential fetch.
    rst = 1'b0; rst8 = 1'b0;
    check("c1_rom_en", bus.rom_en, 0);
    check("c1_addr", bus.addr, 32'h0);
    step();
    check("run_rom_en", bus.rom_en, 1);
    check("seq0", bus.addr, 32'h0);
    step(); check("seq4", bus.addr, 32'h4);
    step(); check("seq8", bus.addr, 32'h8);
    step(); check("seqC", bus.addr, 32'hC);
    step(); check("seq10", bus.addr, 32'h10);

    // Branch while stalled becomes pending, taken on release.
    bus.stall_pc = 1; bus.branch_flag = 1; bus.branch_addr = 32'h100;
    step();
    check("stall_addr", bus.addr, 32'h10);
    check("stall_pend", bus.pend_valid, 1);
    bus.branch_flag = 0;
    step();
    check("stall_hold", bus.addr, 32'h10);
    check("stall_pend2", bus.pend_valid, 1);
    bus.stall_pc = 0;
    step();
    check("pend_taken", bus.addr, 32'h100);
    check("pend_clr", bus.pend_valid, 0);

    // Exception under stall, then eret.
    bus.branch_flag = 1; bus.branch_addr = 32'h40;
    step(); check("br40", bus.addr, 32'h40);
    bus.branch_flag = 0; bus.stall_pc = 1; bus.exc_flag = 1;
    step();
    check("exc_addr", bus.addr, 32'h20);
    check("exc_epc", bus.epc, 32'h40);
    bus.exc_flag = 0; bus.stall_pc = 0;
    step(); check("exc_seq", bus.addr, 32'h24);
    bus.eret_flag = 1;
    step(); check("eret_addr", bus.addr, 32'h40);
    bus.eret_flag = 0;
    check("eret_epc", bus.epc, 32'h40);

    // Misaligned branch raises exception and one-cycle addr_err.
    bus.branch_flag = 1; bus.branch_addr = 32'h50;
    step(); check("br50", bus.addr, 32'h50);
    bus.branch_addr = 32'h102;
    step();
    check("mis_addr", bus.addr, 32'h20);
    check("mis_epc", bus.epc, 32'h50);
    check("mis_err", bus.addr_err, 1);
    bus.branch_flag = 0;
    step();
    check("mis_err_clr", bus.addr_err, 0);
    check("mis_seq", bus.addr, 32'h24);

    // Pending eret is not overwritten by a lower-priority branch.
    bus.branch_flag = 1; bus.branch_addr = 32'h80;
    step(); check("br80", bus.addr, 32'h80);
    bus.branch_flag = 0; bus.exc_flag = 1;
    step(); check("exc2_epc", bus.epc, 32'h80);
    bus.exc_flag = 0; bus.stall_pc = 1; bus.eret_flag = 1;
    step();
    check("peret_pend", bus.pend_valid, 1);
    check("peret_addr", bus.addr, 32'h20);
    bus.eret_flag = 0; bus.branch_flag = 1; bus.branch_addr = 32'h200;
    step(); check("pbr_hold", bus.addr, 32'h20);
    bus.branch_flag = 0; bus.stall_pc = 0;
    step();
    check("prio_addr", bus.addr, 32'h80);
    check("prio_pend", bus.pend_valid, 0);

    // No fetch_ack holds the PC.
    bus.fetch_ack = 0;
    step(); check("noack_hold", bus.addr, 32'h80);
    bus.fetch_ack = 1;

    // Exception beats a simultaneous branch.
    bus.exc_flag = 1; bus.branch_flag = 1; bus.branch_addr = 32'h300;
    step();
    check("excpri_addr", bus.addr, 32'h20);
    check("excpri_epc", bus.epc, 32'h80);
    bus.exc_flag = 0;

    // Asynchronous reset mid-stall discards the pending branch.
    bus.stall_pc = 1; bus.branch_addr = 32'h400;
    step(); check("pre_rst_pend", bus.pend_valid, 1);
    bus.branch_flag = 0; bus.stall_pc = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_addr", bus.addr, 32'h0);
    check("arst_pend", bus.pend_valid, 0);
    check("arst_rom_en", bus.rom_en, 0);
    check("arst_epc", bus.epc, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_addr", bus.addr, 32'h0);
    check("post_rst_rom_en", bus.rom_en, 1);
    step(); check("post_rst_seq", bus.addr, 32'h4);

    // 8-bit wrap and reset with pending redirect.
    bus8.fetch_ack = 1; bus8.branch_flag = 1; bus8.branch_addr = 8'hFC;
    step(); check("w8_fc", bus8.addr, 32'hFC);
    bus8.branch_flag = 0;
    step();
    check("w8_wrap", bus8.addr, 32'h00);
    check("w8_no_err", bus8.addr_err, 0);
    bus8.stall_pc = 1; bus8.branch_flag = 1; bus8.branch_addr = 8'h40;
    step(); check("w8_pend", bus8.pend_valid, 1);
    bus8.branch_flag = 0; bus8.stall_pc = 0;
    #2 rst8 = 1'b1;
    #1;
    check("w8_rst_addr", bus8.addr, 32'h00);
    check("w8_rst_pend", bus8.pend_valid, 0);
    step();
    rst8 = 1'b0;
    step();
    check("w8_post_addr", bus8.addr, 32'h00);
    check("w8_post_pend", bus8.pend_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
